// File: rtl/stage_if.sv
// br32 instruction-fetch stage: owns the fetch PC, drives the imem req/ack port and a
// registered IF output with a one-entry park. Define IF_PERF_CNT_EN to add perf counters.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_exn,
    input  logic [31:0] i_exn_vec,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_nextpc,
    output logic [31:0] o_if_instr,
    output logic        o_if_bubble,
    output logic        o_if_stall,
    input  logic        i_id_branch,
    input  logic [31:0] i_id_branch_dest,
    input  logic        i_id_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_stall,
    output logic [31:0] o_perf_kill
`endif
);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0] r_req_addr, w_req_addr_nxt;
    logic        r_inflight, w_inflight_nxt;
    logic        r_park_valid, w_park_valid_nxt;
    logic [31:0] r_park_pc, w_park_pc_nxt;
    logic [31:0] r_park_instr, w_park_instr_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_nextpc, w_nextpc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_bubble, w_bubble_nxt;
    logic        r_stall;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_hold;
    logic        w_issue;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;

    assign w_redirect = i_exn | i_id_branch;
    assign w_target   = (i_exn ? i_exn_vec : i_id_branch_dest) & ~32'h3;
    assign w_hold     = i_id_stall && !i_exn && !r_bubble;
    assign w_issue    = (r_state == ST_RUN) && !r_inflight && !r_park_valid
                        && !(i_id_stall && !r_bubble);
    // Request is combinational so reset drops it at once and the first fetch goes out
    // in the first cycle out of reset.
    assign w_req      = i_rst_n && (r_inflight || w_issue);
    assign w_addr     = r_inflight ? r_req_addr : r_fetch_pc;
    assign w_ack      = i_imem_ack && w_req;

    assign o_imem_req  = w_req;
    assign o_imem_addr = w_addr;
    assign o_if_pc     = r_pc;
    assign o_if_nextpc = r_nextpc;
    assign o_if_instr  = r_instr;
    assign o_if_bubble = r_bubble;
    assign o_if_stall  = r_stall;

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_req_addr_nxt   = r_req_addr;
        w_inflight_nxt   = r_inflight;
        w_park_valid_nxt = r_park_valid;
        w_park_pc_nxt    = r_park_pc;
        w_park_instr_nxt = r_park_instr;
        w_pc_nxt         = r_pc;
        w_nextpc_nxt     = r_nextpc;
        w_instr_nxt      = r_instr;
        w_bubble_nxt     = r_bubble;
        unique case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_fetch_pc_nxt   = w_target;
                    w_pc_nxt         = w_target;
                    w_nextpc_nxt     = w_target;
                    w_bubble_nxt     = 1'b1;
                    w_park_valid_nxt = 1'b0;
                    if (w_ack) begin
                        w_inflight_nxt = 1'b0;
                    end else if (w_req) begin
                        // A request already on the bus cannot be withdrawn; wait it out.
                        w_state_nxt    = ST_DRAIN;
                        w_inflight_nxt = 1'b1;
                        w_req_addr_nxt = w_addr;
                    end
                end else if (w_ack) begin
                    w_fetch_pc_nxt = w_addr + 32'd4;
                    w_inflight_nxt = 1'b0;
                    if (w_hold) begin
                        w_park_valid_nxt = 1'b1;
                        w_park_pc_nxt    = w_addr;
                        w_park_instr_nxt = i_imem_rdata;
                    end else begin
                        w_pc_nxt     = w_addr;
                        w_nextpc_nxt = w_addr + 32'd4;
                        w_instr_nxt  = i_imem_rdata;
                        w_bubble_nxt = 1'b0;
                    end
                end else begin
                    if (w_req) begin
                        w_inflight_nxt = 1'b1;
                        w_req_addr_nxt = w_addr;
                    end
                    if (!w_hold) begin
                        if (r_park_valid) begin
                            w_park_valid_nxt = 1'b0;
                            w_pc_nxt         = r_park_pc;
                            w_nextpc_nxt     = r_park_pc + 32'd4;
                            w_instr_nxt      = r_park_instr;
                            w_bubble_nxt     = 1'b0;
                        end else begin
                            w_pc_nxt     = r_fetch_pc;
                            w_nextpc_nxt = r_fetch_pc;
                            w_bubble_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_ack) begin
                    w_inflight_nxt = 1'b0;
                    w_state_nxt    = ST_RUN;
                end
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                end
                w_pc_nxt     = w_redirect ? w_target : r_fetch_pc;
                w_nextpc_nxt = w_redirect ? w_target : r_fetch_pc;
                w_bubble_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_fetch_pc   <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_inflight   <= 1'b0;
            r_park_valid <= 1'b0;
            r_park_pc    <= '0;
            r_park_instr <= '0;
            r_pc         <= RESET_PC;
            r_nextpc     <= RESET_PC;
            r_instr      <= '0;
            r_bubble     <= 1'b1;
            r_stall      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_req_addr   <= w_req_addr_nxt;
            r_inflight   <= w_inflight_nxt;
            r_park_valid <= w_park_valid_nxt;
            r_park_pc    <= w_park_pc_nxt;
            r_park_instr <= w_park_instr_nxt;
            r_pc         <= w_pc_nxt;
            r_nextpc     <= w_nextpc_nxt;
            r_instr      <= w_instr_nxt;
            r_bubble     <= w_bubble_nxt;
            r_stall      <= w_bubble_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        w_deliver;
    logic        w_kill;
    logic [31:0] r_perf_fetch, r_perf_stall, r_perf_kill;

    assign w_kill    = w_ack && ((r_state == ST_DRAIN) || w_redirect);
    assign w_deliver = (r_state == ST_RUN) && !w_redirect && !w_hold
                       && (w_ack || r_park_valid);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_kill  <= '0;
        end else begin
            r_perf_fetch <= r_perf_fetch + {31'd0, w_deliver};
            r_perf_stall <= r_perf_stall + {31'd0, r_bubble};
            r_perf_kill  <= r_perf_kill + {31'd0, w_kill};
        end
    end

    assign o_perf_fetch = r_perf_fetch;
    assign o_perf_stall = r_perf_stall;
    assign o_perf_kill  = r_perf_kill;
`endif

endmodule

// File: tb/tb_stage_if.sv
// Randomized bench for stage_if: random-latency memory, decode stalls, branches and
// exceptions, checked each cycle against a transaction-level fetch model.
module tb_stage_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned NCYC     = 4000;

    logic        clk;
    logic        rst_n;
    logic        exn;
    logic [31:0] exn_vec;
    logic [31:0] if_pc, if_nextpc, if_instr;
    logic        if_bubble, if_stall;
    logic        id_branch;
    logic [31:0] id_branch_dest;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, perf_kill;
`endif

    stage_if #(.RESET_PC(RESET_PC)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_exn            (exn),
        .i_exn_vec        (exn_vec),
        .o_if_pc          (if_pc),
        .o_if_nextpc      (if_nextpc),
        .o_if_instr       (if_instr),
        .o_if_bubble      (if_bubble),
        .o_if_stall       (if_stall),
        .i_id_branch      (id_branch),
        .i_id_branch_dest (id_branch_dest),
        .i_id_stall       (id_stall),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata)
`ifdef IF_PERF_CNT_EN
        ,
        .o_perf_fetch     (perf_fetch),
        .o_perf_stall     (perf_stall),
        .o_perf_kill      (perf_kill)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Reference model: next address to deliver, an abandoned request (if any),
    // an outstanding live request, a park queue and the IF output record.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pe_t;

    pe_t         m_park[$];
    logic [31:0] m_next, m_stale_addr;
    bit          m_stale, m_busy, m_init;
    logic [31:0] m_pc, m_npc, m_instr;
    bit          m_bub;
    int unsigned mp_fetch, mp_stall, mp_kill;

    function automatic bit model_req();
        return rst_n && (m_stale || m_busy || (m_park.size() == 0 && !(id_stall && !m_bub)));
    endfunction

    function automatic logic [31:0] model_addr();
        return m_stale ? m_stale_addr : m_next;
    endfunction

    task automatic set_bubble(input logic [31:0] a);
        m_pc = a; m_npc = a; m_bub = 1;
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        m_pc = a; m_npc = a + 32'd4; m_instr = w; m_bub = 0;
        mp_fetch++;
    endtask

    task automatic model_step();
        logic [31:0] tgt, a;
        bit          redir, hold, req;
        pe_t         pw;
        if (!rst_n) begin
            m_next = RESET_PC; m_stale = 0; m_busy = 0; m_park.delete();
            m_pc = RESET_PC; m_npc = RESET_PC; m_instr = '0; m_bub = 1;
            mp_fetch = 0; mp_stall = 0; mp_kill = 0;
            m_init = 1;
        end else begin
            redir = exn || id_branch;
            tgt   = (exn ? exn_vec : id_branch_dest) & 32'hFFFF_FFFC;
            req   = model_req();
            a     = model_addr();
            hold  = id_stall && !exn && !m_bub;
            if (m_bub) mp_stall++;
            if (m_stale) begin
                if (imem_ack) begin m_stale = 0; mp_kill++; end
                if (redir) m_next = tgt;
                set_bubble(m_next);
            end else if (redir) begin
                m_next = tgt;
                m_park.delete();
                set_bubble(tgt);
                if (imem_ack) mp_kill++;
                else if (req) begin m_stale = 1; m_stale_addr = a; end
                m_busy = 0;
            end else if (imem_ack) begin
                m_next = a + 32'd4;
                m_busy = 0;
                if (hold) m_park.push_back('{pc: a, instr: mem_word(a)});
                else set_word(a, mem_word(a));
            end else begin
                if (req) m_busy = 1;
                if (!hold) begin
                    if (m_park.size() != 0) begin
                        pw = m_park.pop_front();
                        set_word(pw.pc, pw.instr);
                    end else begin
                        set_bubble(m_next);
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned k = $urandom_range(0, 9);
        if (k == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
        if (k == 1) return 32'h0000_0103;
        return $urandom & 32'h0000_0FFF;
    endfunction

    int unsigned mem_wait, mem_lat, stall_left;

    initial begin
        rst_n = 0; exn = 0; exn_vec = '0; id_branch = 0; id_branch_dest = '0;
        id_stall = 0; imem_ack = 0; imem_rdata = '0;
        m_init = 0; mem_wait = 0; mem_lat = 0; stall_left = 0;
        for (int unsigned c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst_n = !(c < 3 || (c >= 2000 && c < 2002));
            if (stall_left > 0) begin
                id_stall = 1; stall_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                id_stall = 1; stall_left = $urandom_range(0, 5);
            end else begin
                id_stall = 0;
            end
            id_branch      = !id_stall && ($urandom_range(0, 15) == 0);
            id_branch_dest = rand_target();
            exn            = ($urandom_range(0, 29) == 0);
            exn_vec        = ($urandom_range(0, 3) == 0) ? 32'h0000_0200 : rand_target();
            #1;
            if (m_init) begin
                check("imem_req", {31'd0, imem_req}, {31'd0, model_req()});
                check("imem_addr", imem_addr, model_addr());
            end
            if (imem_req) begin
                if (mem_wait >= mem_lat) begin
                    imem_ack   = 1;
                    imem_rdata = mem_word(imem_addr);
                    mem_wait   = 0;
                    mem_lat    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
                end else begin
                    imem_ack   = 0;
                    imem_rdata = $urandom;
                    mem_wait++;
                end
            end else begin
                imem_ack   = 0;
                imem_rdata = $urandom;
                mem_wait   = 0;
            end
            @(posedge clk);
            model_step();
            #1;
            check("if_pc", if_pc, m_pc);
            check("if_nextpc", if_nextpc, m_npc);
            check("if_bubble", {31'd0, if_bubble}, {31'd0, m_bub});
            check("if_stall", {31'd0, if_stall}, {31'd0, m_bub});
            if (!m_bub || !rst_n) check("if_instr", if_instr, m_instr);
`ifdef IF_PERF_CNT_EN
            check("perf_fetch", perf_fetch, mp_fetch);
            check("perf_stall", perf_stall, mp_stall);
            check("perf_kill", perf_kill, mp_kill);
`endif
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the br32 five-stage pipeline. It owns the fetch PC, issues word requests to instruction memory with a req/ack handshake, and presents a registered fetched instruction to `stage_id`. It is the producing end of `if_out_if` and the consuming end of `id_out_if`: it follows decode stalls and applies branch and exception redirects. A one-entry park register absorbs a memory response that arrives while decode is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `exn`  in  1  exception flush from the back end.
- `exn_vec`  in  32  exception target PC; bits [1:0] are ignored.
- `IF`  `if_out_if.master`: `pc`[31:0], `nextpc`[31:0], `instr`[31:0], `bubble`, `stall`; all registered.
- `ID`  `id_out_if.other`: uses `branch`, `branch_dest`[31:0], `stall`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address; [1:0] always 0.
- `imem_ack`  in  1  response valid this cycle; may be high in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; valid only while `imem_ack` is high.

## Operation
- Registers:
  - `fetch_pc`: next address to issue.
  - `req_addr`: address currently on the bus.
  - `inflight`: request asserted but not yet acked.
  - FSM state: RUN or DRAIN.
  - `park_valid`, `park_pc`, `park_instr`.
- Bus rule: once `imem_req` is high without ack, `imem_req` and `imem_addr` hold until `imem_ack`. Requests are never withdrawn.
- Redirect priority, highest first:
  - reset;
  - `exn` (target `exn_vec & ~3`);
  - `ID.branch` (target `ID.branch_dest & ~3`);
  - sequential (`fetch_pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- RUN state:
  - Issue `fetch_pc` when `!park_valid` and not (`ID.stall` && output valid).
  - On ack, one of two things happens to the response:
    - it loads the output register: `pc=req_addr`, `nextpc=req_addr+4`, `instr=rdata`, `bubble=0`, `stall=0`; or
    - if the output is held, it goes to park.
  - With zero-wait memory, throughput is one instruction per cycle.
- Redirect in a cycle with no ack:
  - `fetch_pc` takes the target.
  - The output loads a bubble: `pc=nextpc=target`, `bubble=1`, `stall=1`.
  - `park_valid` clears.
  - If `inflight`, go to DRAIN.
- Redirect in the same cycle as an ack: the acked word is discarded; no DRAIN.
- DRAIN state:
  - Keep the stale request asserted.
  - On ack, discard the data and return to RUN. The next request is the redirect target, issued the following cycle.
  - A further redirect during DRAIN only updates `fetch_pc`.
- No valid instruction available (waiting on memory or DRAIN): the output shows `bubble=1`, `stall=1`, and `pc=nextpc` = the address of the next instruction to be delivered.
- Output hold:
  - When `ID.stall && !exn`, the output register holds if it contains a valid instruction.
  - A bubble output may always be replaced.
- Park drain: when the hold releases, the output loads from park in that cycle and `park_valid` clears.

## Timing
- Reset values:
  - `IF.pc = IF.nextpc = RESET_PC`, `IF.instr = 0`, `IF.bubble = 1`, `IF.stall = 1`.
  - `imem_req = 0`, `imem_addr = RESET_PC`.
  - State RUN; `inflight = 0`; `park_valid = 0`.
- First request is issued in the first cycle with `rst_n = 1`.
- Reset asserted mid-request drops `imem_req` immediately. The memory must tolerate an abandoned request across reset.
- Latency, zero-wait memory: issue in cycle t, `IF.instr` valid at t+1.
- Latency, k-cycle memory: `IF.instr` valid one cycle after ack.
- Redirect: `ID.branch` in cycle t gives `imem_addr = target` at t+1 when no stale request is in flight.
- Redirect with a stale ack at t+k: target issued at t+k+1.
- `exn` and `ID.branch` in the same cycle: `exn` wins.
- `exn` overrides `ID.stall`; the output flushes to a bubble.

## Configuration
- `IF_PERF_CNT_EN` defined: adds three output ports, each 32-bit, wrapping, cleared by reset:
  - `perf_fetch`: delivered instructions;
  - `perf_stall`: cycles with `IF.bubble` = 1 while not in reset;
  - `perf_kill`: discarded responses.
- Not defined: the ports and counters are absent. Fetch behaviour is identical in both builds.

## Test plan
- Reset release, zero-wait memory returning `addr ^ 32'hA5A5_0000` -> `IF.pc` = 0, 4, 8 on consecutive cycles with `bubble = 0` from the second cycle.
- 3-cycle memory latency -> `bubble = stall = 1` with `pc = 0` for 3 cycles, then `instr` for 0, then for 4, 4 cycles later.
- `ID.branch` with dest 32'h103 while a fetch of 8 waits 2 cycles -> 8 is acked and discarded; next `imem_addr = 32'h100`; `perf_kill` increments.
- `ID.stall` held 4 cycles while an ack for 12 arrives -> `IF` holds pc 8; when the stall drops, pc 12 appears from park the next cycle with no duplicate or lost word.
- `exn` and `ID.branch` in the same cycle with `exn_vec = 32'h200` and dest 32'h40 -> next issue is 32'h200 and the output is a bubble.
- Fetch at 32'hFFFF_FFFC -> next `imem_addr` = 0.
